// File: rtl/br_resolve_pkg.sv
// Shared definitions for the miniRV-1 branch/jump resolution unit.
// Opcodes, branch conditions and the resolver state encoding.
package br_resolve_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_ctl(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/br_resolve_cmp.sv
// Branch condition comparator: evaluates funct3 against two operands.
// Pure combinational; flags the two unused funct3 encodings.
module br_cmp
    import br_resolve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            cond,
    output logic            illegal
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/br_resolve.sv
// Branch/jump resolver: captures operands on halt_pc, evaluates for
// LATENCY cycles, then pulses pc_valid with the resolved next PC.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt_pc,
    input  logic [6:0]      op7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            pc_valid,
    output logic [XLEN-1:0] npc,
    output logic            taken,
    output logic [XLEN-1:0] link,
    output logic            err
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t          state;
    logic [3:0]      cnt;
    logic [6:0]      op_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;

    logic            cond;
    logic            illegal;
    logic [XLEN-1:0] link_c;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] jt;
    logic [XLEN-1:0] r_npc;
    logic            r_taken;
    logic            r_err;

    br_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1     (rs1_q),
        .rs2     (rs2_q),
        .funct3  (f3_q),
        .cond    (cond),
        .illegal (illegal)
    );

    always_comb begin
        link_c  = pc_q + XLEN'(4);
        tgt     = pc_q + imm_q;
        jt      = rs1_q + imm_q;
        jt[0]   = 1'b0;
        r_taken = 1'b0;
        r_npc   = link_c;
        r_err   = 1'b0;
        case (op_q)
            OP_JAL: begin
                r_taken = 1'b1;
                r_npc   = tgt;
            end
            OP_JALR: begin
                r_taken = 1'b1;
                r_npc   = jt;
            end
            default: begin
                r_taken = cond & ~illegal;
                r_err   = illegal;
                if (r_taken)
                    r_npc = tgt;
            end
        endcase
        // Redirect to a non-word-aligned target is reported, not fixed up
        if (r_taken && (r_npc[1:0] != 2'b00))
            r_err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            f3_q     <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            pc_valid <= 1'b0;
            npc      <= '0;
            taken    <= 1'b0;
            link     <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (halt_pc && is_ctl(op7)) begin
                        op_q  <= op7;
                        f3_q  <= funct3;
                        pc_q  <= pc;
                        imm_q <= imm;
                        rs1_q <= rs1_data;
                        rs2_q <= rs2_data;
                        cnt   <= CNT_INIT;
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (cnt == 4'd0) begin
                        npc      <= r_npc;
                        taken    <= r_taken;
                        link     <= link_c;
                        err      <= r_err;
                        pc_valid <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    pc_valid <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    pc_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: one LATENCY=1 and one LATENCY=3 instance
// sharing operand inputs, with hand-computed expected results.
module tb_br_resolve;
    import br_resolve_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        halt1;
    logic        halt3;
    logic [6:0]  op7;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;

    logic        pv1, tk1, er1;
    logic [31:0] np1, lk1;
    logic        pv3, tk3, er3;
    logic [31:0] np3, lk3;

    logic        sel3;
    logic        pv_m, tk_m, er_m;
    logic [31:0] np_m, lk_m;

    int checks;
    int errors;

    br_resolve #(.XLEN(32), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .halt_pc(halt1), .op7(op7),
        .funct3(funct3), .pc(pc), .imm(imm), .rs1_data(rs1),
        .rs2_data(rs2), .pc_valid(pv1), .npc(np1), .taken(tk1),
        .link(lk1), .err(er1)
    );

    br_resolve #(.XLEN(32), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .halt_pc(halt3), .op7(op7),
        .funct3(funct3), .pc(pc), .imm(imm), .rs1_data(rs1),
        .rs2_data(rs2), .pc_valid(pv3), .npc(np3), .taken(tk3),
        .link(lk3), .err(er3)
    );

    assign pv_m = sel3 ? pv3 : pv1;
    assign tk_m = sel3 ? tk3 : tk1;
    assign er_m = sel3 ? er3 : er1;
    assign np_m = sel3 ? np3 : np1;
    assign lk_m = sel3 ? lk3 : lk1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic s3, input logic [6:0] op,
                         input logic [2:0] f3, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk);
        #1;
        sel3   = s3;
        op7    = op;
        funct3 = f3;
        pc     = p;
        imm    = im;
        rs1    = a;
        rs2    = b;
        halt1  = !s3;
        halt3  = s3;
        @(posedge clk);
        #1;
        halt1 = 1'b0;
        halt3 = 1'b0;
    endtask

    task automatic await(input string tag, input int lat,
                         input logic [31:0] e_npc, input logic e_tk,
                         input logic [31:0] e_lk, input logic e_er);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (pv_m) break;
        end
        if (!pv_m) n = 99;
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        chk({tag, ".npc"}, np_m, e_npc);
        chk({tag, ".taken"}, 32'(tk_m), 32'(e_tk));
        chk({tag, ".link"}, lk_m, e_lk);
        chk({tag, ".err"}, 32'(er_m), 32'(e_er));
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 32'(pv_m), 32'd0);
    endtask

    initial begin
        logic seen;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        halt1  = 1'b0;
        halt3  = 1'b0;
        sel3   = 1'b0;
        op7    = '0;
        funct3 = '0;
        pc     = '0;
        imm    = '0;
        rs1    = '0;
        rs2    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pv", 32'(pv1), 32'd0);
        chk("rst.npc", np1, 32'd0);
        chk("rst.link", lk3, 32'd0);
        chk("rst.taken_err", 32'({tk1, er1, tk3, er3}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, OP_BRANCH, F3_BEQ, 32'h100, 32'h20, 32'd5, 32'd5);
        await("beq", 1, 32'h120, 1'b1, 32'h104, 1'b0);
        pulse_end("beq");

        issue(1'b0, OP_BRANCH, F3_BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        await("blt", 1, 32'h240, 1'b1, 32'h204, 1'b0);
        issue(1'b0, OP_BRANCH, F3_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        await("bltu", 1, 32'h204, 1'b0, 32'h204, 1'b0);

        issue(1'b0, OP_JALR, 3'b000, 32'h300, 32'h4, 32'h1003, 32'h0);
        await("jalr", 1, 32'h1006, 1'b1, 32'h304, 1'b1);

        issue(1'b0, OP_BRANCH, 3'b010, 32'h400, 32'h80, 32'd1, 32'd1);
        await("ill", 1, 32'h404, 1'b0, 32'h404, 1'b1);
        pulse_end("ill");

        issue(1'b0, OP_BRANCH, F3_BGE, 32'h700, 32'h8, 32'h8000_0000, 32'd0);
        await("bge", 1, 32'h704, 1'b0, 32'h704, 1'b0);
        issue(1'b0, OP_BRANCH, F3_BGEU, 32'h700, 32'h8, 32'h8000_0000, 32'd0);
        await("bgeu", 1, 32'h708, 1'b1, 32'h704, 1'b0);

        issue(1'b0, OP_BRANCH, F3_BEQ, 32'h800, 32'h2, 32'd3, 32'd3);
        await("misal", 1, 32'h802, 1'b1, 32'h804, 1'b1);

        issue(1'b0, OP_JAL, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0);
        await("wrap", 1, 32'h10, 1'b1, 32'hFFFF_FFF4, 1'b0);

        issue(1'b0, 7'b0110011, 3'b000, 32'h900, 32'h4, 32'd0, 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen = seen | pv1;
        end
        chk("ignore.pv", 32'(seen), 32'd0);

        issue(1'b1, OP_BRANCH, F3_BNE, 32'h500, 32'h10, 32'd7, 32'd9);
        rs1 = 32'd3;
        rs2 = 32'd3;
        pc  = 32'hDEAD_0000;
        imm = 32'h0;
        await("lat3", 3, 32'h510, 1'b1, 32'h504, 1'b0);
        issue(1'b1, OP_JAL, 3'b000, 32'h600, 32'hFFFF_FF00, 32'h0, 32'h0);
        await("b2b", 3, 32'h500, 1'b1, 32'h604, 1'b0);

        issue(1'b1, OP_BRANCH, F3_BEQ, 32'hA00, 32'h40, 32'd1, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.npc", np3, 32'd0);
        chk("arst.link", lk3, 32'd0);
        chk("arst.flags", 32'({pv3, tk3, er3}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | pv3;
        end
        chk("arst.nopv", 32'(seen), 32'd0);
        issue(1'b1, OP_JAL, 3'b000, 32'hB00, 32'h100, 32'h0, 32'h0);
        await("arst.fresh", 3, 32'hC00, 1'b1, 32'hB04, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
